// File: rtl/ps2_pkg.sv
// Shared scancode constants, decoder state type and hex key table
// for the PS/2 hex-entry controller.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    // Set-2 make codes for hex digits 0..F, indexed by digit value
    localparam logic [7:0] HEX_CODES [16] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
    };

endpackage

// File: rtl/ps2_hex_decode.sv
// Combinational lookup from a make code to its hex digit.
module ps2_hex_decode
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (code == HEX_CODES[i[3:0]]) begin
                nibble = i[3:0];
                is_hex = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_entry_ctrl.sv
// Scancode decoder and hex-digit entry buffer with commit, backspace,
// escape and a prefix timeout.
module ps2_entry_ctrl
    import ps2_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk100mhz,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_err,
    output logic [4*DIGITS-1:0]   entry,
    output logic [2:0]            entry_cnt,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  show_value
);

    localparam int W  = 4 * DIGITS;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0]    MAX_CNT  = 3'(DIGITS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    dec_state_t    state;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    nibble;
    logic          is_hex;

    ps2_hex_decode u_hex (
        .code   (rx_data),
        .nibble (nibble),
        .is_hex (is_hex)
    );

    always_ff @(posedge clk100mhz) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            entry       <= '0;
            entry_cnt   <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            show_value  <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (rx_valid) begin
                tmo_cnt <= '0;
                if (rx_err) begin
                    state <= ST_IDLE;
                end else begin
                    unique case (state)
                        ST_IDLE: begin
                            if (rx_data == SC_EXT) begin
                                state <= ST_EXT;
                            end else if (rx_data == SC_BRK) begin
                                state <= ST_BRK;
                            end else begin
                                unique case (1'b1)
                                    is_hex: begin
                                        entry      <= {entry[W-5:0], nibble};
                                        show_value <= 1'b0;
                                        if (entry_cnt != MAX_CNT)
                                            entry_cnt <= entry_cnt + 3'd1;
                                    end
                                    (rx_data == SC_BKSP): begin
                                        if (entry_cnt != 3'd0) begin
                                            entry      <= entry >> 4;
                                            entry_cnt  <= entry_cnt - 3'd1;
                                            show_value <= 1'b0;
                                        end
                                    end
                                    (rx_data == SC_ESC): begin
                                        entry      <= '0;
                                        entry_cnt  <= '0;
                                        show_value <= 1'b0;
                                    end
                                    (rx_data == SC_ENTER): begin
                                        if (entry_cnt != 3'd0) begin
                                            value       <= entry;
                                            value_valid <= 1'b1;
                                            entry       <= '0;
                                            entry_cnt   <= '0;
                                            show_value  <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        ST_EXT: begin
                            state <= (rx_data == SC_BRK) ? ST_EXT_BRK
                                                         : ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (state != ST_IDLE) begin
                // Abandon a dangling prefix once the line has been quiet
                if (tmo_cnt == TMO_LAST) begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_entry_ctrl.sv
// Randomized bench for ps2_entry_ctrl against a queue-based keyboard model,
// with directed scenarios pinned to hand-computed values.
module tb_ps2_entry_ctrl;

    localparam int DIGITS = 4;
    localparam int TMO    = 20;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_err = 1'b0;
    logic [W-1:0] entry;
    logic [2:0]   entry_cnt;
    logic [W-1:0] value;
    logic         value_valid;
    logic         show_value;

    int checks = 0;
    int failures = 0;
    int vv_seen = 0;
    bit cmp_en = 1'b0;

    ps2_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYC(TMO)) dut (
        .clk100mhz   (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .entry       (entry),
        .entry_cnt   (entry_cnt),
        .value       (value),
        .value_valid (value_valid),
        .show_value  (show_value)
    );

    always #5 clk = ~clk;

    // Keyboard model: typed digits as a queue, oldest first
    logic [7:0]   keys [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                8'h36, 8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32,
                                8'h21, 8'h23, 8'h24, 8'h2B};
    logic [3:0]   q [$];
    logic [W-1:0] m_value = '0;
    bit           m_vv = 0;
    bit           m_show = 0;
    bit           seen_e0 = 0;
    bit           seen_f0 = 0;
    int           idle = 0;

    function automatic int hex_of(input logic [7:0] b);
        for (int i = 0; i < 16; i++)
            if (keys[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] m_entry();
        logic [W-1:0] e = '0;
        foreach (q[i]) e = (e << 4) | W'(q[i]);
        return e;
    endfunction

    task automatic model_make(input logic [7:0] b);
        int n = hex_of(b);
        if (n >= 0) begin
            q.push_back(4'(n));
            if (q.size() > DIGITS) void'(q.pop_front());
            m_show = 0;
        end else if (b == 8'h66) begin
            if (q.size() > 0) begin
                void'(q.pop_back());
                m_show = 0;
            end
        end else if (b == 8'h76) begin
            q.delete();
            m_show = 0;
        end else if (b == 8'h5A && q.size() > 0) begin
            m_value = m_entry();
            m_vv = 1;
            q.delete();
            m_show = 1;
        end
    endtask

    task automatic model_step();
        m_vv = 0;
        if (!reset_n) begin
            q.delete();
            m_value = '0;
            m_show = 0;
            seen_e0 = 0;
            seen_f0 = 0;
            idle = 0;
        end else if (rx_valid) begin
            idle = 0;
            if (rx_err || seen_f0) begin
                seen_e0 = 0;
                seen_f0 = 0;
            end else if (seen_e0) begin
                if (rx_data == 8'hF0) seen_f0 = 1;
                else seen_e0 = 0;
            end else if (rx_data == 8'hE0) begin
                seen_e0 = 1;
            end else if (rx_data == 8'hF0) begin
                seen_f0 = 1;
            end else begin
                model_make(rx_data);
            end
        end else if (seen_e0 || seen_f0) begin
            idle++;
            if (idle == TMO) begin
                seen_e0 = 0;
                seen_f0 = 0;
                idle = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t)",
                         name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (value_valid === 1'b1) vv_seen++;
        if (cmp_en) begin
            check("entry", 32'(entry), 32'(m_entry()));
            check("entry_cnt", 32'(entry_cnt), q.size());
            check("value", 32'(value), 32'(m_value));
            check("value_valid", 32'(value_valid), 32'(m_vv));
            check("show_value", 32'(show_value), 32'(m_show));
        end
    end

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        rx_data = b;
        rx_err = err;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err = 1'b0;
    endtask

    task automatic key(input logic [7:0] b);
        send(b);
        send(8'hF0);
        send(b);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int vv0;
    logic [W-1:0] v0;

    initial begin
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_entry", 32'(entry), 32'h0);
        check("rst_value", 32'(value), 32'h0);
        check("rst_show", 32'(show_value), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Commit 01BA
        vv0 = vv_seen;
        key(8'h45); key(8'h16); key(8'h32); key(8'h1C); key(8'h5A);
        idle_cycles(1);
        check("commit_value", 32'(value), 32'h01BA);
        check("commit_pulses", vv_seen - vv0, 1);
        check("commit_entry", 32'(entry), 32'h0);
        check("commit_show", 32'(show_value), 32'h1);

        // Overflow then backspace
        key(8'h2B); key(8'h23); key(8'h36); key(8'h21); key(8'h24);
        check("full_entry", 32'(entry), 32'hD6CE);
        check("full_cnt", 32'(entry_cnt), 32'd4);
        check("model_full", 32'(m_entry()), 32'hD6CE);
        send(8'h66);
        check("bksp_entry", 32'(entry), 32'h0D6C);
        check("bksp_cnt", 32'(entry_cnt), 32'd3);

        // Enter on empty buffer
        send(8'h76);
        vv0 = vv_seen;
        send(8'h5A);
        idle_cycles(1);
        check("empty_enter_pulses", vv_seen - vv0, 0);
        check("empty_enter_value", 32'(value), 32'h01BA);

        // Extended release of Enter, then timeout boundaries
        send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'h1E);
        check("ext_brk_entry", 32'(entry), 32'h0002);
        check("ext_brk_value", 32'(value), 32'h01BA);
        send(8'hF0); idle_cycles(TMO); send(8'h45);
        check("tmo_entry", 32'(entry), 32'h0020);
        check("tmo_cnt", 32'(entry_cnt), 32'd2);
        send(8'hF0); idle_cycles(TMO - 1); send(8'h45);
        check("pre_tmo_entry", 32'(entry), 32'h0020);

        // Receive errors
        send(8'h76);
        send(8'h16, 1'b1);
        check("err_entry", 32'(entry), 32'h0);
        send(8'hF0); send(8'h1E, 1'b1); send(8'h16);
        check("err_brk_entry", 32'(entry), 32'h0001);

        // Reset with a pending break prefix
        send(8'h76);
        send(8'h16); send(8'h1E); send(8'hF0);
        rx_data = 8'h26;
        rx_valid = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        reset_n = 1'b1;
        check("rst_mid_entry", 32'(entry), 32'h0);
        check("rst_mid_value", 32'(value), 32'h0);
        check("rst_mid_cnt", 32'(entry_cnt), 32'h0);
        send(8'h16);
        check("post_rst_entry", 32'(entry), 32'h0001);

        // Random traffic
        for (int c = 0; c < 6000; c++) begin
            int r;
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                rx_valid = ($urandom_range(0, 1) == 1);
                @(negedge clk);
                reset_n = 1'b1;
                rx_valid = 1'b0;
            end else if ($urandom_range(0, 80) == 0) begin
                idle_cycles($urandom_range(TMO - 1, TMO + 1));
            end else if ($urandom_range(0, 9) < 4) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2, 3: rx_data = keys[$urandom_range(0, 15)];
                    4: rx_data = 8'hE0;
                    5: rx_data = 8'hF0;
                    6: rx_data = 8'h5A;
                    7: rx_data = 8'h66;
                    8: rx_data = 8'h76;
                    default: rx_data = 8'($urandom);
                endcase
                send(rx_data, $urandom_range(0, 29) == 0);
            end else begin
                @(negedge clk);
            end
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
